// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 mux: FSM state encoding and mode constants.
package mux_pkg;

  typedef enum logic {
    S_MAN  = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_next_idx.sv
// Circular next-enabled-channel finder: first enabled index above cur, else the lowest
// enabled index at or below cur (which counts as a wrap).
module mux_next_idx #(
  parameter int N_CH = 8
) (
  input  logic [$clog2(N_CH)-1:0] cur_i,
  input  logic [N_CH-1:0]         ch_en_i,
  output logic [$clog2(N_CH)-1:0] nxt_o,
  output logic                    wrap_o,
  output logic                    any_en_o
);

  localparam int SEL_W = $clog2(N_CH);

  logic hi_found;

  // NOTE: combinational blocks use blocking '=' and give every output a default first,
  // so no latch is inferred and later loop iterations see earlier results.
  always_comb begin
    nxt_o    = cur_i;
    wrap_o   = 1'b0;
    hi_found = 1'b0;
    // Descending scans so the lowest qualifying index is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en_i[i] && (i > int'(cur_i))) begin
        nxt_o    = SEL_W'(i);
        hi_found = 1'b1;
      end
    end
    if (!hi_found) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ch_en_i[i] && (i <= int'(cur_i))) begin
          nxt_o  = SEL_W'(i);
          wrap_o = 1'b1;
        end
      end
    end
  end

  assign any_en_o = |ch_en_i;

endmodule : mux_next_idx

// File: rtl/mux_scan_reg.sv
// Registered N:1 data mux with channel-enable mask, manual select and an auto-scan mode
// that dwells DWELL cycles per enabled channel and pulses scan_wrap on pointer wrap.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int DWELL = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*W-1:0]       din,
  input  logic [$clog2(N_CH)-1:0] sel,
  input  logic                    mode,
  input  logic [N_CH-1:0]         ch_en,
  output logic [W-1:0]            dout,
  output logic [$clog2(N_CH)-1:0] dout_ch,
  output logic                    dout_vld,
  output logic                    scan_wrap
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       dout_q, dout_d;
  logic [SEL_W-1:0]   dout_ch_q, dout_ch_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;

  logic [SEL_W-1:0]   find_src;
  logic [SEL_W-1:0]   find_nxt;
  logic               find_wrap;
  logic               any_en;
  logic               sel_ok;
  logic               cur_ok;

  // Manual mode searches from sel (for the scan entry point), scan mode from cur.
  assign find_src = (state_q == S_MAN) ? sel : cur_q;

  mux_next_idx #(.N_CH(N_CH)) u_next_idx (
    .cur_i    (find_src),
    .ch_en_i  (ch_en),
    .nxt_o    (find_nxt),
    .wrap_o   (find_wrap),
    .any_en_o (any_en)
  );

  assign sel_ok = (int'(sel) < N_CH) && ch_en[sel];
  assign cur_ok = ch_en[cur_q];

  always_comb begin
    state_d   = mode ? S_SCAN : S_MAN;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dout_ch_d = dout_ch_q;
    vld_d     = 1'b0;
    wrap_d    = 1'b0;
    unique case (state_q)
      S_MAN: begin
        cnt_d = '0;
        if (sel_ok) begin
          dout_d    = din[int'(sel)*W +: W];
          dout_ch_d = sel;
          vld_d     = 1'b1;
        end
        if (mode == MODE_SCAN) begin
          if (sel_ok)      cur_d = sel;
          else if (any_en) cur_d = find_nxt;
        end
      end
      S_SCAN: begin
        if (cur_ok) begin
          dout_d    = din[int'(cur_q)*W +: W];
          dout_ch_d = cur_q;
          vld_d     = 1'b1;
        end
        // Leaving scan takes priority over any pending dwell expiry.
        if (mode == MODE_MAN) begin
          cnt_d = '0;
        end else if (!any_en) begin
          cnt_d = cnt_q;
        end else if (!cur_ok || (cnt_q == DWELL_LAST)) begin
          cnt_d  = '0;
          cur_d  = find_nxt;
          wrap_d = find_wrap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking '<=' so all flops sample
  // the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_MAN;
      cur_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      dout_ch_q <= '0;
      vld_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      dout_ch_q <= dout_ch_d;
      vld_q     <= vld_d;
      wrap_q    <= wrap_d;
    end
  end

  assign dout      = dout_q;
  assign dout_ch   = dout_ch_q;
  assign dout_vld  = vld_q;
  assign scan_wrap = wrap_q;

endmodule : mux_scan_reg

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N:1 data multiplexer; the next generation of the team's clocked 8:1 byte mux.
- Generalised in channel count and width.
- Adds a channel-enable mask, an auto-scan mode with a programmable dwell time, an output valid flag, the selected-channel tag and a scan-wrap pulse.
- Sits between parallel sample sources and a single downstream consumer (display, UART framer, logger).

Parameters:
- N_CH, 8, number of input channels (2..64).
- W, 8, data width per channel (1..64).
- DWELL, 20, clock cycles spent on each channel in scan mode (>=1).
- SEL_W, $clog2(N_CH), derived localparam (not overridable); index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N_CH*W  flattened channel data; channel k = din[k*W +: W].
- sel  in  SEL_W  channel index used in manual mode.
- mode  in  1  0 = manual, 1 = scan.
- ch_en  in  N_CH  per-channel enable mask.
- dout  out  W  registered selected data.
- dout_ch  out  SEL_W  index of the channel that produced dout.
- dout_vld  out  1  dout/dout_ch are valid this cycle.
- scan_wrap  out  1  one-cycle pulse when the scan pointer wraps.

Behaviour:
- Reset (rst_n low, async): dout=0, dout_ch=0, dout_vld=0, scan_wrap=0, cur=0, cnt=0, state=S_MAN. All outputs are flops; no combinational path from inputs to outputs.
- States:
  - S_MAN: entered when mode=0.
  - S_SCAN: entered when mode=1.
  - mode is sampled every clk; the state follows mode one cycle later.
- Manual (S_MAN):
  - Each edge: if sel<N_CH and ch_en[sel], then dout<=din[sel], dout_ch<=sel, dout_vld<=1. Latency 1 cycle from sel/din to dout.
  - Otherwise dout and dout_ch hold and dout_vld<=0.
  - cnt is held at 0; scan_wrap=0.
- Transition S_MAN->S_SCAN:
  - cur<=sel if sel is enabled, else next enabled index after sel (circular); cnt<=0.
  - First scan output appears on the following edge.
- Scan (S_SCAN):
  - Each edge with ch_en[cur]=1: dout<=din[cur], dout_ch<=cur, dout_vld<=1, cnt<=cnt+1.
  - When cnt==DWELL-1: cnt<=0 and cur<=next enabled index after cur (search cur+1 .. N_CH-1, then 0 .. cur, circular).
  - scan_wrap<=1 for exactly one cycle when the new cur <= old cur. This includes a single enabled channel re-selecting itself.
  - DWELL=1: advances every cycle.
- Scan boundary conditions:
  - ch_en==0: dout_vld<=0, dout and dout_ch hold, cur and cnt hold, no scan_wrap.
  - Current channel disabled mid-dwell: no output from it; cur advances on the next edge to the next enabled channel; cnt<=0.
  - ch_en changes to enable a channel ahead of cur: picked up at the next natural advance, not immediately.
- Transition S_SCAN->S_MAN: cnt<=0, scan_wrap<=0; manual rules apply from the next edge. cur retains its value.
- Simultaneous events:
  - mode change and dwell expiry in the same cycle: the mode change wins and no advance/wrap occurs.
  - Reset asserted mid-dwell: all state clears immediately (async); resumes in S_MAN after rst_n deasserts, with outputs at their reset values until the first edge.
- Data width: straight W-bit copy; no arithmetic on data. cnt width = $clog2(DWELL+1).

Decomposition:
- Shared package/include mux_pkg: state encoding (S_MAN=1'b0, S_SCAN=1'b1), MODE_MAN/MODE_SCAN constants, and a clog2 helper if the tools require one.
- One sub-module, mux_next_idx: combinational circular next-enabled-index finder.
  - Inputs: cur index, ch_en.
  - Outputs: next index, wrap flag, any_en.
  - Parametrised by N_CH.

Test Plan:
- Manual sweep: N_CH=8, W=8, din = {93,67,ff,3d,a3,45,12,34} (ch7..ch0), ch_en=8'hFF, mode=0, sel stepped 0..7 every 20 cycles -> dout = 34,12,45,a3,3d,ff,67,93, one cycle after each sel change; dout_vld=1 throughout.
- Manual disabled channel: ch_en=8'hFB, sel=2 -> dout_vld=0 and dout holds the previous value (12 from sel=1). Then sel=3 -> dout=a3, dout_vld=1.
- Scan with DWELL=4, ch_en=8'h0F, mode=1 from sel=0 -> dout_ch sequence 0,0,0,0,1,1,1,1,2..3,0. scan_wrap is high for exactly the one cycle cur goes 3->0.
- Scan with mask holes: ch_en=8'h82, DWELL=2 -> dout alternates 12,12,93,93,12,...; scan_wrap pulses on each 7->1 transition.
- Mid-dwell disable: scanning ch2 at cnt=1, clear ch_en[2] -> next cycle dout_ch=3, cnt restarts. ch_en=0 -> dout_vld=0, dout frozen.
- Reset and mode race: assert rst_n low mid-scan -> all outputs 0 immediately. Mode toggled 1->0 on the dwell-expiry cycle -> no advance and no scan_wrap.
